// File: rtl/iic_init_seq.sv
// iic_init_seq: power-up register-table sequencer sitting in front of IIC_ctrl.
// Walks CMD_NUM (byte address, data) entries and issues one single-byte-address
// I2C write per entry, waiting for completion before moving on.
// Optional build macro IIC_INIT_VERIFY_EN adds a read-back of every write,
// with up to two rewrites of an entry whose read-back does not match.
// Handshake: exactly one command is in flight at a time. wr_en/rd_en,
// byte_addr and wr_data are set in LOAD/RD_LOAD and held until the command
// completes; i2c_start is held for START_HOLD cycles; completion is only the
// synchronized rising edge of i2c_end (end_pls) seen while in WAIT.
module iic_init_seq #(
    parameter int CMD_NUM        = 8,
    parameter int START_HOLD     = 100,
    parameter int GAP_CYCLES     = 1000,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int AUTO_START     = 1
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       start,
    output logic [7:0] cmd_idx,
    input  logic [7:0] cmd_byte_addr,
    input  logic [7:0] cmd_wr_data,
    output logic       wr_en,
    output logic       rd_en,
    output logic       i2c_start,
    output logic       addr_num,
    output logic [7:0] byte_addr,
    output logic [7:0] wr_data,
    input  logic       i2c_end,
    input  logic [7:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] err_idx
);

    localparam logic [7:0]  LAST_IDX = 8'(CMD_NUM - 1);
    localparam logic [31:0] HOLD_END = 32'(START_HOLD - 1);
    localparam logic [31:0] GAP_END  = 32'(GAP_CYCLES - 1);
    localparam logic [31:0] TMO_END  = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_DONE,
        S_ERR
`ifdef IIC_INIT_VERIFY_EN
        ,
        S_RD_LOAD,
        S_CHECK
`endif
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] cnt;
    logic        auto_pend;
    logic        sync1;
    logic        sync2;
    logic        sync3;
    logic        end_pls;

    logic        cnt_clr;
    logic        idx_clr;
    logic        idx_inc;
    logic        tbl_ld;
    logic        cmd_drop;
    logic        err_ld;

`ifdef IIC_INIT_VERIFY_EN
    logic        rd_ld;
    logic        retry_inc;
    logic        retry_clr;
    logic        last_rd;
    logic [1:0]  retry;
    logic [7:0]  rd_cap;
`endif

    // Register address is always a single byte.
    assign addr_num = 1'b0;

    // i2c_end comes from the slower i2c_clk domain: two sync stages, then an edge register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= i2c_end;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign end_pls = sync2 & ~sync3;

    // FSM state register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        idx_clr   = 1'b0;
        idx_inc   = 1'b0;
        tbl_ld    = 1'b0;
        cmd_drop  = 1'b0;
        err_ld    = 1'b0;
`ifdef IIC_INIT_VERIFY_EN
        rd_ld     = 1'b0;
        retry_inc = 1'b0;
        retry_clr = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (start || auto_pend) begin
                    idx_clr   = 1'b1;
                    state_nxt = S_LOAD;
                end
            end
            S_DONE, S_ERR: begin
                if (start) begin
                    idx_clr   = 1'b1;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                tbl_ld    = 1'b1;
                cnt_clr   = 1'b1;
                state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (cnt == HOLD_END) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // Completion wins over a timeout landing on the same cycle.
                if (end_pls) begin
                    cmd_drop  = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = S_GAP;
                end else if (cnt == TMO_END) begin
                    cmd_drop  = 1'b1;
                    err_ld    = 1'b1;
                    state_nxt = S_ERR;
                end
            end
            S_GAP: begin
                if (cnt == GAP_END) begin
`ifdef IIC_INIT_VERIFY_EN
                    state_nxt = last_rd ? S_CHECK : S_RD_LOAD;
`else
                    if (cmd_idx == LAST_IDX) begin
                        state_nxt = S_DONE;
                    end else begin
                        idx_inc   = 1'b1;
                        state_nxt = S_LOAD;
                    end
`endif
                end
            end
`ifdef IIC_INIT_VERIFY_EN
            S_RD_LOAD: begin
                rd_ld     = 1'b1;
                cnt_clr   = 1'b1;
                state_nxt = S_ISSUE;
            end
            S_CHECK: begin
                if (rd_cap == wr_data) begin
                    retry_clr = 1'b1;
                    if (cmd_idx == LAST_IDX) begin
                        state_nxt = S_DONE;
                    end else begin
                        idx_inc   = 1'b1;
                        state_nxt = S_LOAD;
                    end
                end else if (retry == 2'd2) begin
                    err_ld    = 1'b1;
                    state_nxt = S_ERR;
                end else begin
                    retry_inc = 1'b1;
                    state_nxt = S_LOAD;
                end
            end
`endif
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Command, index, counter and status registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt       <= '0;
            auto_pend <= (AUTO_START != 0);
            cmd_idx   <= '0;
            byte_addr <= '0;
            wr_data   <= '0;
            wr_en     <= 1'b0;
            i2c_start <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_idx   <= '0;
        end else begin
            auto_pend <= 1'b0;
            cnt       <= cnt_clr ? '0 : cnt + 32'd1;
            i2c_start <= (state_nxt == S_ISSUE);
            busy      <= (state_nxt != S_IDLE) && (state_nxt != S_DONE) && (state_nxt != S_ERR);
            done      <= (state_nxt == S_DONE);
            err       <= (state_nxt == S_ERR);
            if (idx_clr) begin
                cmd_idx <= '0;
            end else if (idx_inc) begin
                cmd_idx <= cmd_idx + 8'd1;
            end
            if (tbl_ld) begin
                byte_addr <= cmd_byte_addr;
                wr_data   <= cmd_wr_data;
                wr_en     <= 1'b1;
            end else if (cmd_drop) begin
                wr_en <= 1'b0;
            end
            if (err_ld) begin
                err_idx <= cmd_idx;
            end else if (idx_clr) begin
                err_idx <= '0;
            end
        end
    end

`ifdef IIC_INIT_VERIFY_EN
    // Read-back command, captured read data and per-entry retry count.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_en   <= 1'b0;
            last_rd <= 1'b0;
            retry   <= '0;
            rd_cap  <= '0;
        end else begin
            if (rd_ld) begin
                rd_en   <= 1'b1;
                last_rd <= 1'b1;
            end else if (tbl_ld) begin
                last_rd <= 1'b0;
            end else if (cmd_drop) begin
                rd_en <= 1'b0;
            end
            if (state == S_WAIT && end_pls) begin
                rd_cap <= rd_data;
            end
            if (idx_clr || retry_clr) begin
                retry <= '0;
            end else if (retry_inc) begin
                retry <= retry + 2'd1;
            end
        end
    end
`else
    logic unused_rd_data;

    assign rd_en          = 1'b0;
    assign unused_rd_data = ^rd_data;
`endif

endmodule
